// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads words from instruction memory, screens them for
// supported encodings and hands them in order to the decoder over valid/ready.
module instr_fetch_unit #(
    parameter int unsigned           ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]     LAST_ADDR = 16'h0DEF,
    parameter logic [5:0]            OP_R      = 6'd3,
    parameter logic [5:0]            OP_LW     = 6'd4,
    parameter logic [5:0]            OP_SW     = 6'd5,
    parameter logic [5:0]            FN_SUB    = 6'd34,
    parameter logic [5:0]            FN_MUL    = 6'd50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [ADDR_W-1:0] err_pc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_infl_pc;
    logic [ADDR_W-1:0]   r_err_pc;
    logic                r_inflight;
    logic                r_err_flag;

    logic [31:0]         r_buf_word [2];
    logic [ADDR_W-1:0]   r_buf_pc   [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;

    logic                w_idle_like;
    logic                w_start_ok;
    logic                w_start_oor;
    logic [5:0]          w_op;
    logic [5:0]          w_fn;
    logic                w_legal;
    logic                w_ret_live;
    logic                w_push;
    logic                w_bad;
    logic                w_valid;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_issue;
    logic                w_last_issue;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
    assign w_start_ok  = start && w_idle_like;
    assign w_start_oor = (start_addr > LAST_ADDR);

    assign w_op    = imem_rdata[31:26];
    assign w_fn    = imem_rdata[5:0];
    assign w_legal = (w_op == OP_LW) || (w_op == OP_SW) ||
                     ((w_op == OP_R) && ((w_fn == FN_SUB) || (w_fn == FN_MUL)));

    // Returns arriving after an illegal word has been seen are dropped.
    assign w_ret_live = r_inflight && !r_err_flag;
    assign w_push     = w_ret_live && w_legal;
    assign w_bad      = w_ret_live && !w_legal;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && instr_ready;

    // Words owed to the buffer after this cycle must never exceed its depth.
    assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_FETCH) && !w_bad && (w_occ < 3'd2);
    assign w_last_issue = w_issue && (r_pc == LAST_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_next = w_start_oor ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_bad || w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == 2'd0) && !r_inflight) begin
                    w_state_next = r_err_flag ? S_ERR : S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_FETCH, S_DRAIN: busy    = 1'b1;
            S_DONE:           done    = 1'b1;
            S_ERR:            illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_infl_pc  <= '0;
            r_inflight <= 1'b0;
            r_err_flag <= 1'b0;
            r_err_pc   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_pc <= r_pc;
            end
            if (w_start_ok) begin
                r_pc       <= start_addr;
                r_err_flag <= 1'b0;
                r_err_pc   <= '0;
            end else begin
                if (w_issue && !w_last_issue) begin
                    r_pc <= r_pc + 1'b1;
                end
                if (w_bad) begin
                    r_err_flag <= 1'b1;
                    r_err_pc   <= r_infl_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset: the head is only exposed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_word[r_wptr] <= imem_rdata;
            r_buf_pc[r_wptr]   <= r_infl_pc;
        end
    end

    assign imem_en     = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_buf_word[r_rptr] : 32'd0;
    assign instr_pc    = w_valid ? r_buf_pc[r_rptr]   : '0;
    assign err_pc      = r_err_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed runs push expected beats,
// a negedge monitor pops and compares every accepted instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] err_pc;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .err_pc      (err_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr[11:0]];
    end

    typedef struct packed {
        logic [31:0] w;
        logic [15:0] pc;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int xfer_cnt = 0;
    int outstanding = 0;
    int first_xfer_cyc = 0;
    int last_xfer_cyc = 0;
    bit chk_out = 1'b0;
    bit prev_stall = 1'b0;
    logic [47:0] prev_beat = '0;

    localparam logic [31:0] W_LW  = 32'h110009F0;
    localparam logic [31:0] W_SUB = 32'h0C2022A2;
    localparam logic [31:0] W_MUL = 32'h0C8532B2;
    localparam logic [31:0] W_SW  = 32'h15060DEF;
    localparam logic [31:0] W_BAD = 32'hFC000000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and polices the handshake rules.
    always @(negedge clk) begin
        if (rst_n) begin
            logic pop;
            pop = instr_valid && instr_ready;
            if (prev_stall) begin
                chk("stable_while_stalled", 64'({instr_pc, instr}), 64'(prev_beat));
                chk("valid_held_while_stalled", 64'(instr_valid), 64'(1));
            end
            if (imem_en) begin
                en_cnt++;
                if (chk_out) chk("outstanding_le_2", 64'((outstanding + 1 - int'(pop)) <= 2), 64'(1));
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got pc %0h word %0h expected none", instr_pc, instr);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_word", 64'(instr), 64'(e.w));
                    chk("beat_pc", 64'(instr_pc), 64'(e.pc));
                    $display("beat pc=%0h word=%08h", instr_pc, instr);
                end
                if (xfer_cnt == 0) first_xfer_cyc = cyc;
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            outstanding = outstanding + int'(imem_en) - int'(pop);
            prev_stall = instr_valid && !instr_ready;
            prev_beat  = {instr_pc, instr};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] addr);
        start = 1'b1;
        start_addr = addr;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_stats();
        en_cnt = 0;
        xfer_cnt = 0;
        outstanding = 0;
        prev_stall = 1'b0;
    endtask

    task automatic load_prog(input int n);
        logic [31:0] words [4];
        words[0] = W_LW; words[1] = W_SUB; words[2] = W_MUL; words[3] = W_SW;
        for (int i = 0; i < n; i++) exp_q.push_back({words[i], 16'(16'h0DEC + i)});
    endtask

    task automatic wait_not_busy(input string name, input int bound);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < bound);
        chk({name, "_finish_in_time"}, 64'(busy), 64'(0));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_imem_en"},     64'(imem_en),     64'(0));
        chk({name, "_imem_addr"},   64'(imem_addr),   64'(0));
        chk({name, "_instr"},       64'(instr),       64'(0));
        chk({name, "_instr_pc"},    64'(instr_pc),    64'(0));
        chk({name, "_instr_valid"}, 64'(instr_valid), 64'(0));
        chk({name, "_busy"},        64'(busy),        64'(0));
        chk({name, "_done"},        64'(done),        64'(0));
        chk({name, "_illegal"},     64'(illegal),     64'(0));
        chk({name, "_err_pc"},      64'(err_pc),      64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[12'hDEC] = W_LW; mem[12'hDED] = W_SUB; mem[12'hDEE] = W_MUL; mem[12'hDEF] = W_SW;

        // 1: asynchronous reset, checked before any clock edge
        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // 2: normal run, latency, throughput, done timing
        clear_stats(); chk_out = 1'b1; instr_ready = 1'b1; load_prog(4);
        pulse_start(16'h0DEC);
        @(negedge clk);
        chk("n_first_imem_en", 64'(imem_en), 64'(1));
        chk("n_first_imem_addr", 64'(imem_addr), 64'(16'h0DEC));
        chk("n_valid_cyc1", 64'(instr_valid), 64'(0));
        @(negedge clk);
        chk("n_valid_cyc2", 64'(instr_valid), 64'(0));
        @(negedge clk);
        chk("n_valid_cyc3", 64'(instr_valid), 64'(1));
        wait_not_busy("normal", 30);
        chk("n_done", 64'(done), 64'(1));
        chk("n_illegal", 64'(illegal), 64'(0));
        chk("n_en_count", 64'(en_cnt), 64'(4));
        chk("n_xfer_count", 64'(xfer_cnt), 64'(4));
        chk("n_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("n_no_bubbles", 64'(last_xfer_cyc - first_xfer_cyc), 64'(3));
        chk("n_done_edge_after_last", 64'(cyc - last_xfer_cyc), 64'(2));
        $display("run normal done=%0d en=%0d xfers=%0d", done, en_cnt, xfer_cnt);

        // 3: backpressure in cycles 3..8
        tick(); clear_stats(); load_prog(4);
        pulse_start(16'h0DEC);
        for (int c = 1; c <= 9; c++) begin
            instr_ready = (c < 3) || (c > 8);
            tick();
        end
        wait_not_busy("bp", 40);
        chk("bp_done", 64'(done), 64'(1));
        chk("bp_en_count", 64'(en_cnt), 64'(4));
        chk("bp_xfer_count", 64'(xfer_cnt), 64'(4));
        chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("run backpressure done=%0d en=%0d xfers=%0d", done, en_cnt, xfer_cnt);

        // 4: illegal word at 0x0DEE
        mem[12'hDEE] = W_BAD;
        tick(); clear_stats(); chk_out = 1'b0; load_prog(2);
        pulse_start(16'h0DEC);
        wait_not_busy("ill", 30);
        chk("ill_illegal", 64'(illegal), 64'(1));
        chk("ill_done", 64'(done), 64'(0));
        chk("ill_err_pc", 64'(err_pc), 64'(16'h0DEE));
        chk("ill_en_count", 64'(en_cnt), 64'(3));
        chk("ill_xfer_count", 64'(xfer_cnt), 64'(2));
        chk("ill_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("run illegal illegal=%0d err_pc=%0h en=%0d", illegal, err_pc, en_cnt);
        mem[12'hDEE] = W_MUL;

        // 5a: out-of-range start
        tick(); clear_stats();
        pulse_start(16'h0E00);
        chk("oor_done", 64'(done), 64'(1));
        chk("oor_busy", 64'(busy), 64'(0));
        chk("oor_illegal_cleared", 64'(illegal), 64'(0));
        chk("oor_err_pc_cleared", 64'(err_pc), 64'(0));
        repeat (3) tick();
        chk("oor_no_imem_en", 64'(en_cnt), 64'(0));
        $display("run out_of_range done=%0d en=%0d", done, en_cnt);

        // 5b: start while busy is ignored
        clear_stats(); chk_out = 1'b1; load_prog(4);
        pulse_start(16'h0DEC);
        tick();
        pulse_start(16'h0000);
        wait_not_busy("ign", 30);
        chk("ign_done", 64'(done), 64'(1));
        chk("ign_en_count", 64'(en_cnt), 64'(4));
        chk("ign_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("run start_while_busy done=%0d xfers=%0d", done, xfer_cnt);

        // 6: reset mid-run after the 2nd transfer, then a clean restart
        tick(); clear_stats(); load_prog(4);
        pulse_start(16'h0DEC);
        begin
            int k;
            k = 0;
            while (xfer_cnt < 2 && k < 20) begin
                @(posedge clk);
                #2;
                k++;
            end
            chk("mr_two_xfers", 64'(xfer_cnt), 64'(2));
        end
        #1 rst_n = 1'b0;
        #1 check_zero("mr_reset");
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_en_in_reset", 64'(imem_en), 64'(0));
        end
        #2 rst_n = 1'b1;
        tick();
        clear_stats(); load_prog(4);
        pulse_start(16'h0DEC);
        wait_not_busy("restart", 30);
        chk("restart_done", 64'(done), 64'(1));
        chk("restart_xfer_count", 64'(xfer_cnt), 64'(4));
        chk("restart_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("run reset_restart done=%0d xfers=%0d", done, xfer_cnt);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
